// File: rtl/schoolbook_result_serializer.sv
// Result serializer for the schoolbook multiplier: captures one N-bit product
// and streams it LSW-first as W-bit words over a valid/ready port.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge where
// valid & ready are both 1. A producer never drops valid or changes its data
// until that transfer has occurred.
module schoolbook_result_serializer #(
  parameter int N = 1142,
  parameter int W = 64,
  localparam int NW = (N + W - 1) / W,
  localparam int CW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_idx,
  output logic          out_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state;
  logic [N-1:0]        cap;
  logic [NW*W-1:0]     cap_pad;
  logic [CW-1:0]       nxt_idx;
  logic [W-1:0]        nxt_word;

  // Zero-extend so the top word reads zeros above bit N-1.
  always_comb begin
    cap_pad = '0;
    cap_pad[N-1:0] = cap;
  end

  // Saturate so the select never walks past the padded register.
  assign nxt_idx  = (out_idx == LAST_IDX) ? out_idx : out_idx + 1'b1;
  assign nxt_word = cap_pad[nxt_idx*W +: W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cap       <= in_data;
            out_data  <= in_data[W-1:0];
            out_idx   <= '0;
            out_last  <= (NW == 1);
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= SEND;
          end else begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
          end
        end
        SEND: begin
          // in_ready stays low here, so a product can never be reloaded
          // in the same cycle as the last-word transfer.
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              out_idx   <= '0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              out_idx  <= nxt_idx;
              out_data <= nxt_word;
              out_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_schoolbook_result_serializer.sv
// Directed + randomized bench for schoolbook_result_serializer; expected words
// come from a queue filled by shifting the captured product arithmetically.
module tb_schoolbook_result_serializer;

  localparam int N  = 1142;
  localparam int W  = 64;
  localparam int NW = (N + W - 1) / W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_idx;
  logic          out_last;

  schoolbook_result_serializer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  // ---------------- clock ----------------
  always #5 clk = clk_run ? ~clk : 1'b0;

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int  exp_idx = 0;
  bit  seen_edge = 1'b0;
  bit  captured = 1'b0;
  int  cycle = 0;
  int  cap_cycle = 0;
  int  last_xfer_cycle = 0;
  int  xfers = 0;
  int  vectors = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load_model(input logic [N-1:0] prod);
    logic [N-1:0] sh;
    for (int k = 0; k < NW; k++) begin
      sh = prod >> (k * W);
      exp_q.push_back(sh[W-1:0]);
    end
    exp_idx = 0;
  endtask

  // Called at a falling edge with inputs already driven; checks outputs,
  // advances the model for the coming rising edge, then waits one cycle.
  task automatic tick();
    bit exp_ready;
    exp_ready = seen_edge && (exp_q.size() == 0);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("out_data", out_data, exp_q[0]);
      chk("out_idx", out_idx, exp_idx);
      chk("out_last", out_last, exp_idx == NW - 1);
    end
    if (exp_q.size() > 0 && out_ready) begin
      void'(exp_q.pop_front());
      exp_idx++;
      xfers++;
      if (exp_q.size() == 0) last_xfer_cycle = cycle;
    end else if (exp_ready && in_valid) begin
      load_model(in_data);
      cap_cycle = cycle;
      captured = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    seen_edge = 1'b1;
    cycle++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    clk_run = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_idx", out_idx, '0);
    chk("rst_out_last", out_last, 1'b0);
    exp_q.delete();
    exp_idx = 0;
    seen_edge = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3 rst = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1'b0);
    clk_run = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
  endtask

  task automatic set_ready(input int mode, input int k);
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ((k % 3) == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic capture(input logic [N-1:0] prod);
    int guard;
    in_data  = prod;
    in_valid = 1'b1;
    captured = 1'b0;
    guard = 0;
    while (!captured && guard < 10) begin
      tick();
      guard++;
    end
    if (!captured) chk("capture_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int mode, input int inject_idx, input int abort_idx);
    int k;
    bit injected;
    k = 0;
    injected = 1'b0;
    xfers = 0;
    while (exp_q.size() > 0 && k < 400) begin
      if (abort_idx >= 0 && exp_idx == abort_idx) return;
      set_ready(mode, k);
      if (inject_idx >= 0 && exp_idx == inject_idx && !injected) begin
        in_valid = 1'b1;
        in_data  = '1;
        injected = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      k++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 1'b0, 1'b1);
    chk("xfer_count", xfers, NW);
  endtask

  task automatic run_product(input logic [N-1:0] prod, input int mode,
                             input int inject_idx, input int abort_idx);
    out_ready = (mode == 0);
    capture(prod);
    drain(mode, inject_idx, abort_idx);
    if (abort_idx < 0) begin
      out_ready = 1'b0;
      tick();
    end
  endtask

  function automatic logic [N-1:0] ramp_product();
    logic [N-1:0] p;
    p = '0;
    for (int k = 0; k < 17; k++) p[k*64 +: 64] = 64'h0101_0101_0101_0101 * k;
    p[17*64 +: 54] = '1;
    return p;
  endfunction

  function automatic logic [N-1:0] rand_product();
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i += 32) p = (p << 32) | N'($urandom);
    return p;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] prod_a;
    int guard;

    // Reset with the clock stopped, then first edge raises in_ready.
    do_reset();

    // Full drain, no backpressure: 18 consecutive transfers.
    run_product(ramp_product(), 0, -1, -1);
    chk("drain_cycles", last_xfer_cycle - cap_cycle, NW);

    // Backpressure pattern 1,0,0,1,...
    run_product(ramp_product(), 1, -1, -1);

    // in_valid with all-ones at idx 5 must be ignored.
    run_product(N'(1), 0, 5, -1);

    // Back-to-back: A = 2^1141 then B = 1 with in_valid held high.
    prod_a = '0;
    prod_a[N-1] = 1'b1;
    out_ready = 1'b1;
    capture(prod_a);
    in_valid = 1'b1;
    in_data  = N'(1);
    captured = 1'b0;
    xfers = 0;
    guard = 0;
    while (!captured && guard < 40) begin
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (!captured) chk("b2b_timeout", 1'b0, 1'b1);
    chk("b2b_a_xfers", xfers, NW);
    chk("b2b_gap", cap_cycle - last_xfer_cycle, 1);
    drain(0, -1, -1);
    out_ready = 1'b0;
    tick();

    // Reset mid-stream at idx 9, then a fresh product of 5.
    run_product(rand_product(), 0, -1, 9);
    chk("abort_at_idx", out_idx, 9);
    do_reset();
    run_product(N'(5), 0, -1, -1);

    // Random products under random backpressure.
    for (int r = 0; r < 4; r++) run_product(rand_product(), 2, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/schoolbook_result_serializer.md
Name: schoolbook_result_serializer

Overview:
- Downstream stage of the 571x571 schoolbook multiplier.
- Captures one full-width product (1142 bits by default) in a single-cycle handshake.
- Streams the product least-significant word first as W-bit words over a valid/ready interface to a narrow bus or a reduction stage.
- Decouples the wide multiplier result register from a narrow consumer, and provides backpressure to the multiplier control.

Parameters:
- N, 1142, product width in bits; N >= 1.
- W, 64, output word width in bits; 1 <= W <= N.
- NW, ceil(N/W) = 18 at defaults, derived: number of output words.
- CW, max(1, clog2(NW)) = 5 at defaults, derived: index width.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  product available from the multiplier.
- in_ready  output  1  serializer can accept a product.
- in_data  input  N  product value.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  W  current word.
- out_idx  output  CW  index of the current word, 0 = least significant.
- out_last  output  1  current word is word NW-1.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- While rst=1, independent of clk: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, capture register=0.
- in_ready rises on the first clk edge after rst deasserts.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at a clk edge: capture in_data into an N-bit register, set idx=0, go to SEND.
- SEND:
  - in_ready=0, out_valid=1.
  - out_data = capture[idx*W +: W]. Bits at or above N read as 0, so the top word is zero-padded (54 valid bits + 10 zero bits at defaults).
  - out_idx = idx.
  - out_last = (idx == NW-1).
- Word transfer occurs on out_valid & out_ready at a clk edge:
  - if idx < NW-1: idx <= idx+1;
  - else go to IDLE.
- Latency: first word is visible on the cycle after capture. With out_ready held at 1, a product drains in NW cycles. in_ready is 1 again on the cycle after the last transfer, giving a minimum capture-to-capture interval of NW+1 cycles.
- No same-cycle reload: in_ready stays 0 during the last-word transfer cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- out_valid never deasserts without a completed transfer, except on reset.
- in_valid while in SEND is ignored; in_data is not sampled and no state changes.
- in_data only needs to be stable during the capture cycle.
- The capture register changes only on capture or reset.
- Reset mid-stream: the partial stream is abandoned immediately and outputs take their reset values. No resume after reset.
- NW=1 case (W >= N): SEND emits a single word with out_last=1 and idx=0.
- out_data may be driven from a shift register or a mux on idx. Either is acceptable if the above observable behaviour holds.

Test Plan:
- Reset/idle: assert rst mid-cycle with clk stopped -> out_valid=0, out_data=0, in_ready=0 immediately. After deassert plus 1 edge -> in_ready=1, out_valid=0.
- Full drain, no backpressure: in_data = 1142-bit value with word k = 64'h0101_0101_0101_0101*k for k=0..16 and word 17 = 54'h3F_FFFF_FFFF_FFFF. out_ready=1 throughout -> exactly 18 consecutive transfers with idx 0..17 and matching words. Word 17 reads 64'h003F_FFFF_FFFF_FFFF with out_last=1 only on idx 17. in_ready=1 on the following cycle.
- Backpressure: same product, out_ready toggled 1,0,0,1,... -> every word is held stable while stalled, no word is skipped or duplicated, and the total transfer count is 18.
- Ignored input: pulse in_valid with in_data = all-ones at idx 5 of a stream of product 0x1 -> the stream continues outputting word 0 = 0x1 then zeros. The all-ones value is never captured.
- Back-to-back products: hold in_valid=1 with product A = 2^1141 then product B = 1 -> A streams with word 17 = 64'h0020_0000_0000_0000. B is captured 1 cycle after A's last transfer, and B's word 0 = 1.
- Reset mid-stream: assert rst at idx 9 -> outputs clear. After release, a new product of 0x5 streams from idx 0 with word 0 = 0x5.
